wallace_mac_ctrl: RTL and testbench

- Sequencer that wraps one wallace_gen instance (signed N-bit × signed W-bit operands, N+W-1-bit product output).
- Computes a signed dot product of cfg_len operand pairs.
- Operands stream in over a valid/ready handshake; they are registered, multiplied and accumulated, and one result is held on a valid/ready output.
- This is the per-lane MAC controller for CNN convolution windows.

---
 rtl/wallace_mac_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_wallace_mac_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wallace_mac_ctrl.sv
// Per-lane signed MAC sequencer: streams cfg_len operand pairs through a
// carry-save (Wallace) multiplier and accumulates a wrapping dot product.

module wallace_gen #(
  parameter int N = 16,
  parameter int W = 5
) (
  input  logic [N-1:0]     a,
  input  logic [W-1:0]     b,
  output logic [N+W-2:0]   p
);
  localparam int PW   = N + W - 1;
  localparam int ROWS = W + 1;

  function automatic int rows_at(input int l);
    int r;
    r = ROWS;
    for (int i = 0; i < l; i++) r = (r / 3) * 2 + r % 3;
    return r;
  endfunction

  function automatic int num_levels();
    int l;
    l = 0;
    for (int i = 0; i < ROWS; i++) if (rows_at(i) > 2) l = i + 1;
    return l;
  endfunction

  localparam int LEVELS = num_levels();

  logic [PW-1:0]            a_ext;
  logic [ROWS-1:0][PW-1:0]  pp;

  assign a_ext = {{(W-1){a[N-1]}}, a};

  // Row W-1 carries the negative weight of b's sign bit as ~x plus a +1 row.
  for (genvar i = 0; i < W-1; i++) begin : g_pp
    assign pp[i] = b[i] ? (a_ext << i) : '0;
  end
  assign pp[W-1] = b[W-1] ? ~(a_ext << (W-1)) : '0;
  assign pp[W]   = {{(PW-1){1'b0}}, b[W-1]};

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int RIN  = rows_at(l);
    localparam int FG   = RIN / 3;
    localparam int LO   = RIN % 3;
    localparam int ROUT = 2 * FG + LO;

    logic [RIN-1:0][PW-1:0]  rin;
    logic [ROUT-1:0][PW-1:0] rout;

    if (l == 0) begin : g_src
      assign rin = pp;
    end else begin : g_src
      assign rin = g_lvl[l-1].rout;
    end

    for (genvar g = 0; g < FG; g++) begin : g_csa
      assign rout[2*g]   = rin[3*g] ^ rin[3*g+1] ^ rin[3*g+2];
      assign rout[2*g+1] = ((rin[3*g] & rin[3*g+1]) | (rin[3*g] & rin[3*g+2]) |
                            (rin[3*g+1] & rin[3*g+2])) << 1;
    end
    for (genvar k = 0; k < LO; k++) begin : g_pass
      assign rout[2*FG+k] = rin[3*FG+k];
    end
  end

  assign p = g_lvl[LEVELS-1].rout[0] + g_lvl[LEVELS-1].rout[1];
endmodule

module wallace_mac_ctrl #(
  parameter int N     = 16,
  parameter int W     = 5,
  parameter int LEN_W = 8,
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] cfg_len,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf,
  output logic             out_corner
);
  localparam int PW = N + W - 1;
  localparam logic [N-1:0]     A_MIN      = {1'b1, {(N-1){1'b0}}};
  localparam logic [W-1:0]     B_MIN      = {1'b1, {(W-1){1'b0}}};
  localparam logic [ACC_W-1:0] CORNER_ADD = ACC_W'(1) << (N + W - 2);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [N-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic               v_q, v_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               ovf_q, ovf_d;
  logic               corner_q, corner_d;

  logic [PW-1:0]      prod;
  logic               corner_hit;
  logic [ACC_W-1:0]   addend;
  logic [ACC_W-1:0]   acc_sum;
  logic               ovf_hit;

  wallace_gen #(.N(N), .W(W)) u_mul (
    .a (a_q),
    .b (b_q),
    .p (prod)
  );

  // The truncated product of min*min wraps negative; substitute the true value.
  assign corner_hit = (a_q == A_MIN) && (b_q == B_MIN);
  assign addend     = corner_hit ? CORNER_ADD : {{(ACC_W-PW){prod[PW-1]}}, prod};
  assign acc_sum    = acc_q + addend;
  assign ovf_hit    = (acc_q[ACC_W-1] == addend[ACC_W-1]) &&
                      (acc_sum[ACC_W-1] != acc_q[ACC_W-1]);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    v_d       = 1'b0;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    corner_d  = corner_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    if (v_q) begin
      acc_d = acc_sum;
      if (ovf_hit)    ovf_d    = 1'b1;
      if (corner_hit) corner_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d    = '0;
          ovf_d    = 1'b0;
          corner_d = 1'b0;
          cnt_d    = cfg_len;
          state_d  = (cfg_len != '0) ? S_LOAD : S_DONE;
        end
      end
      S_LOAD: begin
        in_ready = (cnt_q != '0);
        if (in_valid && in_ready) begin
          a_d   = in_a;
          b_d   = in_b;
          v_d   = 1'b1;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == LEN_W'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      v_q      <= 1'b0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
      corner_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      v_q      <= v_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
      corner_q <= corner_d;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign out_acc    = acc_q;
  assign out_ovf    = ovf_q;
  assign out_corner = corner_q;
endmodule

// File: tb/tb_wallace_mac_ctrl.sv
// Randomized scoreboard bench for wallace_mac_ctrl; a narrow accumulator
// (21 bits) makes wrap-around and the overflow flag easy to reach.

module tb_wallace_mac_ctrl;
  localparam int N     = 16;
  localparam int W     = 5;
  localparam int LEN_W = 8;
  localparam int ACC_W = 21;
  localparam int A_MIN = -(1 << (N-1));
  localparam int B_MIN = -(1 << (W-1));

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [LEN_W-1:0] cfg_len;
  logic             busy;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_acc;
  logic             out_ovf;
  logic             out_corner;

  wallace_mac_ctrl #(.N(N), .W(W), .LEN_W(LEN_W), .ACC_W(ACC_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cfg_len    (cfg_len),
    .busy       (busy),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_acc    (out_acc),
    .out_ovf    (out_ovf),
    .out_corner (out_corner)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint acc;
    bit     ovf;
    bit     corner;
  } exp_t;

  exp_t   sbq[$];
  exp_t   mon_e;
  int     n_chk  = 0;
  int     n_fail = 0;
  longint cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint acc_s();
    return longint'($signed(out_acc));
  endfunction

  // Reference: exact products summed in wide arithmetic, wrapped to ACC_W.
  function automatic exp_t model(input int len, input int qa[$], input int qb[$]);
    exp_t   e;
    longint lim, s;
    lim = longint'(1) <<< (ACC_W-1);
    s = 0;
    e.ovf = 0;
    e.corner = 0;
    for (int i = 0; i < len; i++) begin
      s = s + longint'(qa[i]) * longint'(qb[i]);
      if (s >= lim || s < -lim) begin
        e.ovf = 1;
        s = (s + lim) % (2 * lim);
        if (s < 0) s = s + 2 * lim;
        s = s - lim;
      end
      if (qa[i] == A_MIN && qb[i] == B_MIN) e.corner = 1;
    end
    e.acc = s;
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        mon_e = sbq.pop_front();
        check("out_acc", acc_s(), mon_e.acc);
        check("out_ovf", longint'(out_ovf), longint'(mon_e.ovf));
        check("out_corner", longint'(out_corner), longint'(mon_e.corner));
      end
    end
  end

  task automatic run_job(input int len, input int qa[$], input int qb[$], input exp_t e,
                         input int gap_pct, input bit toggle, input bit noisy,
                         input int wait_cyc);
    int     i, t, nrdy, bad;
    bit     got;
    longint hs_cyc, ov_cyc, st_cyc;
    sbq.push_back(e);
    start = 1; cfg_len = LEN_W'(len);
    @(posedge clk); #1;
    start = 0;
    st_cyc = cyc;
    hs_cyc = 0;
    i = 0; t = 0;
    while (i < len && t < 2000) begin
      in_valid = toggle ? (t % 2 == 0) : (int'($urandom_range(99)) >= gap_pct);
      in_a = N'(qa[i]);
      in_b = W'(qb[i]);
      start = noisy && ($urandom_range(2) == 0);
      cfg_len = LEN_W'($urandom_range(5));
      @(negedge clk);
      if (in_valid && in_ready) begin
        i++;
        hs_cyc = cyc;
      end
      @(posedge clk); #1;
      t++;
    end
    if (t >= 2000) check("input_timeout", t, 0);
    start = 0;
    in_valid = 1; in_a = N'($urandom); in_b = W'($urandom);
    got = 0; t = 0; nrdy = 0; ov_cyc = 0;
    while (!got && t < 50) begin
      @(negedge clk);
      if (in_ready) nrdy++;
      if (out_valid) begin
        got = 1;
        ov_cyc = cyc;
      end else begin
        @(posedge clk); #1;
        t++;
      end
    end
    check("out_valid_seen", longint'(got), 1);
    check("no_extra_pair", nrdy, 0);
    if (len == 0) check("zero_len_latency", ov_cyc - st_cyc, 0);
    else          check("last_pair_latency", ov_cyc - hs_cyc, 2);
    bad = 0;
    for (int k = 0; k < wait_cyc; k++) begin
      @(posedge clk); #1;
      start = noisy && ($urandom_range(1) == 0);
      @(negedge clk);
      if (out_valid !== 1'b1 || acc_s() != e.acc) bad++;
    end
    if (wait_cyc > 0) check("hold_stable", bad, 0);
    @(posedge clk); #1;
    start = 0;
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    in_valid = 0;
    @(negedge clk);
    check("valid_dropped", longint'(out_valid), 0);
    check("idle_after_accept", longint'(busy), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   qa[$], qb[$];
    exp_t e;
    int   len, rdy;

    rst = 1; start = 0; cfg_len = '0; in_valid = 0; in_a = '0; in_b = '0; out_ready = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("rst_busy", longint'(busy), 0);
    check("rst_in_ready", longint'(in_ready), 0);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_out_acc", acc_s(), 0);
    check("rst_out_ovf", longint'(out_ovf), 0);
    check("rst_out_corner", longint'(out_corner), 0);
    @(posedge clk); #1;

    // basic back-to-back
    qa = '{100, -7, 1000}; qb = '{3, -4, 15};
    e.acc = 15328; e.ovf = 0; e.corner = 0;
    run_job(3, qa, qb, e, 0, 0, 0, 0);

    // corner product
    qa = '{A_MIN}; qb = '{B_MIN};
    e.acc = 524288; e.ovf = 0; e.corner = 1;
    run_job(1, qa, qb, e, 0, 0, 0, 0);

    // two corners overflow the 21-bit accumulator
    qa = '{A_MIN, A_MIN}; qb = '{B_MIN, B_MIN};
    e.acc = -1048576; e.ovf = 1; e.corner = 1;
    run_job(2, qa, qb, e, 0, 0, 0, 1);

    // gaps, backpressure, ignored start pulses
    qa = '{1234, -32767, 77, -500}; qb = '{-5, 7, 15, -16};
    e.acc = 1234*(-5) + (-32767)*7 + 77*15 + (-500)*(-16);
    e.ovf = 0; e.corner = 0;
    run_job(4, qa, qb, e, 0, 1, 1, 5);

    // zero length
    qa = {}; qb = {};
    e.acc = 0; e.ovf = 0; e.corner = 0;
    run_job(0, qa, qb, e, 0, 0, 0, 2);

    // reset after 2 of 4 pairs
    start = 1; cfg_len = 4;
    @(posedge clk); #1;
    start = 0;
    rdy = 0;
    for (int k = 0; k < 20 && rdy < 2; k++) begin
      in_valid = 1; in_a = N'(300 + k); in_b = W'(7);
      @(negedge clk);
      if (in_ready) rdy++;
      @(posedge clk); #1;
    end
    in_valid = 0;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    check("midrst_busy", longint'(busy), 0);
    check("midrst_out_valid", longint'(out_valid), 0);
    check("midrst_acc", acc_s(), 0);
    @(posedge clk); #1;
    qa = '{5}; qb = '{-3};
    e.acc = -15; e.ovf = 0; e.corner = 0;
    run_job(1, qa, qb, e, 0, 0, 0, 0);

    // randomized jobs against the reference model
    for (int j = 0; j < 25; j++) begin
      len = $urandom_range(1, 8);
      qa = {}; qb = {};
      for (int k = 0; k < len; k++) begin
        qa.push_back(($urandom_range(5) == 0) ? A_MIN : int'($signed(16'($urandom))));
        qb.push_back(($urandom_range(4) == 0) ? B_MIN : int'($urandom_range(31)) - 16);
      end
      e = model(len, qa, qb);
      run_job(len, qa, qb, e, $urandom_range(40), 0, $urandom_range(1), $urandom_range(3));
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
